// File: rtl/pong_match_sequencer.sv
// Pong match controller: attract/serve/rally/point/over sequencing, scores and per-frame physics gating.
// Optional PONG_AUTO_RESTART_EN: OVER times out back to ATTRACT after 4*POINT_FRAMES frames.
module pong_match_sequencer #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       v_sync,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       frame_tick,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_startup,
  output logic       game_over
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned BLINK_W = 8;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
`ifdef PONG_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(4 * POINT_FRAMES - 1);
`endif

  typedef enum logic [2:0] {
    ST_ATTRACT,
    ST_SERVE,
    ST_RALLY,
    ST_POINT,
    ST_OVER
  } state_e;

  state_e               state_q, state_d;
  logic                 vs_q, vs_d;
  logic                 vs_prev_q, vs_prev_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 start_q, start_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 sq_q, sq_d;
  logic                 ball_run_q, ball_run_d;
  logic                 serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0]   score_p1_q, score_p1_d;
  logic [SCORE_W-1:0]   score_p2_q, score_p2_d;
  logic                 game_startup_q, game_startup_d;
  logic                 game_over_q, game_over_d;

  logic                 start_rise_c;
  logic [SCORE_W-1:0]   p1_next_c;
  logic [SCORE_W-1:0]   p2_next_c;

  assign start_rise_c = start & ~start_q;
  assign p1_next_c    = score_p1_q + SCORE_W'(1);
  assign p2_next_c    = score_p2_q + SCORE_W'(1);

  // Next-state and next-output logic; every state entry clears the frame counters.
  always_comb begin
    vs_d           = v_sync;
    vs_prev_d      = vs_q;
    frame_tick_d   = vs_prev_q & ~vs_q;
    start_d        = start;
    state_d        = state_q;
    cnt_d          = cnt_q;
    blink_d        = blink_q;
    sq_d           = sq_q;
    serve_dir_d    = serve_dir_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    ball_run_d     = 1'b0;
    game_startup_d = 1'b0;
    game_over_d    = 1'b0;

    case (state_q)
      ST_ATTRACT: begin
        if (start_rise_c) begin
          state_d     = ST_SERVE;
          cnt_d       = '0;
          blink_d     = '0;
          sq_d        = 1'b1;
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (frame_tick_q) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_RALLY;
            cnt_d   = '0;
            blink_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              sq_d    = ~sq_q;
            end else begin
              blink_d = blink_q + BLINK_W'(1);
            end
          end
        end
      end
      ST_RALLY: begin
        // Player 1 wins a tie; the player who conceded receives the next serve.
        if (goal_p1) begin
          score_p1_d  = p1_next_c;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
          state_d     = (p1_next_c == WIN_VAL) ? ST_OVER : ST_POINT;
        end else if (goal_p2) begin
          score_p2_d  = p2_next_c;
          serve_dir_d = 1'b0;
          cnt_d       = '0;
          state_d     = (p2_next_c == WIN_VAL) ? ST_OVER : ST_POINT;
        end
      end
      ST_POINT: begin
        if (frame_tick_q) begin
          if (cnt_q == POINT_LAST) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
            blink_d = '0;
            sq_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_rise_c) begin
          state_d     = ST_SERVE;
          cnt_d       = '0;
          blink_d     = '0;
          sq_d        = 1'b1;
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = 1'b0;
        end
`ifdef PONG_AUTO_RESTART_EN
        else if (frame_tick_q) begin
          if (cnt_q == OVER_LAST) begin
            state_d    = ST_ATTRACT;
            cnt_d      = '0;
            score_p1_d = '0;
            score_p2_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = ST_ATTRACT;
        cnt_d   = '0;
        blink_d = '0;
      end
    endcase

    // Outputs follow the state being entered so they are valid one cycle after the event.
    ball_run_d     = (state_d == ST_RALLY);
    game_startup_d = (state_d == ST_ATTRACT);
    game_over_d    = (state_d == ST_OVER);
    if (state_d != ST_SERVE) begin
      sq_d = (state_d == ST_RALLY);
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      vs_q           <= 1'b1;
      vs_prev_q      <= 1'b1;
      frame_tick_q   <= 1'b0;
      start_q        <= 1'b0;
      state_q        <= ST_ATTRACT;
      cnt_q          <= '0;
      blink_q        <= '0;
      sq_q           <= 1'b0;
      ball_run_q     <= 1'b0;
      serve_dir_q    <= 1'b0;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      game_startup_q <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      vs_q           <= vs_d;
      vs_prev_q      <= vs_prev_d;
      frame_tick_q   <= frame_tick_d;
      start_q        <= start_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      blink_q        <= blink_d;
      sq_q           <= sq_d;
      ball_run_q     <= ball_run_d;
      serve_dir_q    <= serve_dir_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      game_startup_q <= game_startup_d;
      game_over_q    <= game_over_d;
    end
  end

  assign frame_tick   = frame_tick_q;
  assign ball_run     = ball_run_q;
  assign serve_dir    = serve_dir_q;
  assign sq_shown     = sq_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign game_startup = game_startup_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer; frames are 16 clocks with v_sync low for 3 of them.
// Honours PONG_AUTO_RESTART_EN when the design is built with it.
module tb_pong_match_sequencer;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       v_sync;
  logic       start;
  logic       goal_p1;
  logic       goal_p2;
  logic       frame_tick;
  logic       ball_run;
  logic       serve_dir;
  logic       sq_shown;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_startup;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int vs_cyc = 0;

  pong_match_sequencer dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .v_sync       (v_sync),
    .start        (start),
    .goal_p1      (goal_p1),
    .goal_p2      (goal_p2),
    .frame_tick   (frame_tick),
    .ball_run     (ball_run),
    .serve_dir    (serve_dir),
    .sq_shown     (sq_shown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_startup (game_startup),
    .game_over    (game_over)
  );

  always #5 clk_0 = ~clk_0;

  initial begin
    v_sync = 1'b1;
    forever begin
      @(negedge clk_0);
      vs_cyc++;
      v_sync = ((vs_cyc % 16) < 13);
    end
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  // Waits until the ball is released, counting frame ticks on the way.
  task automatic wait_rally(output int ticks, output bit ok);
    int cyc;
    ticks = 0;
    cyc   = 0;
    while (ball_run !== 1'b1 && cyc < 3000) begin
      if (frame_tick === 1'b1) ticks++;
      step();
      cyc++;
    end
    ok = (ball_run === 1'b1);
  endtask

  task automatic goal_and_rally(input bit p1);
    int  t;
    bit  ok;
    @(negedge clk_0);
    if (p1) goal_p1 = 1'b1; else goal_p2 = 1'b1;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    wait_rally(t, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL goal_and_rally timeout: ball_run=%0b required 1", ball_run);
    end
  endtask

  task automatic test_reset();
    int n;
    int ticks;
    rst = 1'b0; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
    repeat (3) step();
    checks++;
    if ({game_startup, game_over, ball_run, sq_shown, serve_dir, frame_tick, score_p1, score_p2} !== 14'b10_0000_0000_0000) begin
      errors++;
      $display("FAIL reset_values: got %b required %b",
               {game_startup, game_over, ball_run, sq_shown, serve_dir, frame_tick, score_p1, score_p2}, 14'b10_0000_0000_0000);
    end
    @(negedge clk_0);
    rst = 1'b1;
    n = 0;
    while (v_sync !== 1'b1 && n < 40) begin step(); n++; end
    while (v_sync !== 1'b0 && n < 40) begin step(); n++; end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL vsync_align timeout: v_sync=%0b required 0", v_sync);
    end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_delay0: got %0b required 0", frame_tick); end
    step();
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_delay1: got %0b required 1", frame_tick); end
    step();
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_pulse_width: got %0b required 0", frame_tick); end
    ticks = 0;
    repeat (48) begin step(); if (frame_tick === 1'b1) ticks++; end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_count_3frames: got %0d required 3", ticks); end
    checks++;
    if ({game_startup, ball_run, sq_shown, score_p1, score_p2} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL attract_idle: got %b required %b", {game_startup, ball_run, sq_shown, score_p1, score_p2}, 11'b100_0000_0000);
    end
  endtask

  task automatic test_serve_start();
    int ticks, toggles, bad, cyc;
    logic prev;
    @(negedge clk_0);
    start = 1'b1;
    step();
    checks++;
    if ({game_startup, sq_shown, ball_run, serve_dir} !== 4'b0100) begin
      errors++;
      $display("FAIL serve_entry: got %b required 0100", {game_startup, sq_shown, ball_run, serve_dir});
    end
    ticks = 0; toggles = 0; bad = 0; cyc = 0;
    prev = sq_shown;
    while (ball_run !== 1'b1 && cyc < 2000) begin
      if (sq_shown !== prev) begin
        toggles++;
        if (ticks % 8 != 0) bad++;
        prev = sq_shown;
      end
      if (frame_tick === 1'b1) ticks++;
      step();
      cyc++;
      if (cyc == 160) start = 1'b0;
    end
    checks++;
    if (ball_run !== 1'b1) begin errors++; $display("FAIL serve_timeout: ball_run=%0b required 1", ball_run); end
    checks++;
    if (ticks != 60) begin errors++; $display("FAIL serve_length: got %0d ticks required 60", ticks); end
    checks++;
    if (toggles != 7) begin errors++; $display("FAIL blink_toggles: got %0d required 7", toggles); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blink_phase: got %0d misplaced toggles required 0", bad); end
    checks++;
    if ({sq_shown, game_startup, score_p1, score_p2} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL rally_entry: got %b required 1000000000", {sq_shown, game_startup, score_p1, score_p2});
    end
  endtask

  task automatic test_goal_p2();
    int  ticks, cyc, t;
    bit  ok;
    @(negedge clk_0);
    goal_p2 = 1'b1;
    step();
    goal_p2 = 1'b0;
    checks++;
    if ({score_p1, score_p2, serve_dir, ball_run, sq_shown} !== 11'b0000_0001_000) begin
      errors++;
      $display("FAIL goal_p2_point: got %b required 00000001000", {score_p1, score_p2, serve_dir, ball_run, sq_shown});
    end
    ticks = 0; cyc = 0;
    while (sq_shown !== 1'b1 && cyc < 1000) begin
      if (frame_tick === 1'b1) ticks++;
      goal_p1 = (cyc == 100);
      step();
      cyc++;
    end
    goal_p1 = 1'b0;
    checks++;
    if (ticks != 30) begin errors++; $display("FAIL point_length: got %0d ticks required 30", ticks); end
    checks++;
    if (score_p1 !== 4'd0) begin errors++; $display("FAIL goal_in_point: score_p1=%0d required 0", score_p1); end
    @(negedge clk_0);
    goal_p2 = 1'b1;
    step();
    goal_p2 = 1'b0;
    step();
    checks++;
    if ({score_p2, ball_run, game_startup} !== 6'b0001_00) begin
      errors++;
      $display("FAIL goal_in_serve: got %b required 000100", {score_p2, ball_run, game_startup});
    end
    wait_rally(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL serve_after_point timeout: ball_run=%0b required 1", ball_run); end
  endtask

  task automatic test_simultaneous();
    int t;
    bit ok;
    @(negedge clk_0);
    goal_p1 = 1'b1;
    goal_p2 = 1'b1;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    checks++;
    if ({score_p1, score_p2, serve_dir, ball_run} !== 10'b0001_0001_10) begin
      errors++;
      $display("FAIL simultaneous_goal: got %b required 0001000110", {score_p1, score_p2, serve_dir, ball_run});
    end
    wait_rally(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL simultaneous_rally timeout: ball_run=%0b required 1", ball_run); end
  endtask

  task automatic test_reset_mid();
    goal_and_rally(1'b1);
    goal_and_rally(1'b0);
    goal_and_rally(1'b1);
    checks++;
    if ({score_p1, score_p2, ball_run} !== 9'b0011_0010_1) begin
      errors++;
      $display("FAIL score_3_2: got %b required 001100101", {score_p1, score_p2, ball_run});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({game_startup, game_over, ball_run, sq_shown, serve_dir, frame_tick, score_p1, score_p2} !== 14'b10_0000_0000_0000) begin
      errors++;
      $display("FAIL async_reset: got %b required %b",
               {game_startup, game_over, ball_run, sq_shown, serve_dir, frame_tick, score_p1, score_p2}, 14'b10_0000_0000_0000);
    end
    @(negedge clk_0);
    rst = 1'b1;
    repeat (40) step();
    checks++;
    if ({game_startup, game_over, ball_run, sq_shown, score_p1, score_p2} !== 12'b1000_0000_0000) begin
      errors++;
      $display("FAIL post_reset_attract: got %b required 100000000000", {game_startup, game_over, ball_run, sq_shown, score_p1, score_p2});
    end
  endtask

  task automatic test_game_over();
    int  t, ticks, cyc;
    bit  ok;
    @(negedge clk_0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rally(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL match_start timeout: ball_run=%0b required 1", ball_run); end
    for (int k = 0; k < 6; k++) goal_and_rally(1'b1);
    @(negedge clk_0);
    goal_p1 = 1'b1;
    step();
    goal_p1 = 1'b0;
    checks++;
    if ({game_over, game_startup, ball_run, sq_shown, serve_dir, score_p1, score_p2} !== 13'b10001_0111_0000) begin
      errors++;
      $display("FAIL win_p1: got %b required 1000101110000", {game_over, game_startup, ball_run, sq_shown, serve_dir, score_p1, score_p2});
    end
    ticks = 0; cyc = 0;
    while (game_startup !== 1'b1 && cyc < 2080) begin
      if (frame_tick === 1'b1) ticks++;
      goal_p2 = (cyc == 5);
      step();
      cyc++;
    end
    goal_p2 = 1'b0;
`ifdef PONG_AUTO_RESTART_EN
    checks++;
    if (ticks != 120) begin errors++; $display("FAIL over_timeout: got %0d ticks required 120", ticks); end
    checks++;
    if ({game_startup, game_over, score_p1, score_p2} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL auto_attract: got %b required 1000000000", {game_startup, game_over, score_p1, score_p2});
    end
`else
    checks++;
    if ({game_startup, game_over, ball_run, score_p1, score_p2} !== 11'b010_0111_0000) begin
      errors++;
      $display("FAIL over_held: got %b required 01001110000", {game_startup, game_over, ball_run, score_p1, score_p2});
    end
`endif
    @(negedge clk_0);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({game_over, game_startup, sq_shown, ball_run, serve_dir, score_p1, score_p2} !== 13'b00100_0000_0000) begin
      errors++;
      $display("FAIL restart_serve: got %b required 0010000000000", {game_over, game_startup, sq_shown, ball_run, serve_dir, score_p1, score_p2});
    end
  endtask

  initial begin
    test_reset();
    test_serve_start();
    test_goal_p2();
    test_simultaneous();
    test_reset_mid();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
